// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch prefetch buffer.
package ifu_pkg;

   // Fetch FSM: IDLE has nothing in flight, REQ waits on one response,
   // DROP waits on a response that a redirect has made stale.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StDrop = 2'd2
   } ifu_state_e;

   // Bytes per instruction for the default 32-bit instruction width.
   localparam int unsigned INST_BYTES = 4;

   // PC increment for an arbitrary instruction width.
   function automatic int unsigned inst_bytes(input int unsigned inst_w);
      return inst_w / 8;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO with flush; head data is shown combinationally.
module ifu_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_en, pop_en;

   assign push_en = push_i && (count_q < CntW'(DEPTH));
   assign pop_en  = pop_i && (count_q != '0);

   // Pointer/count update; flush wins over any same-cycle push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk_i) begin
      if (push_en && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ifu_prefetch_buf.sv
// Instruction-fetch front end: single-outstanding request/response fetch
// into a prefetch FIFO, with redirect flushing and stale-response discard.
module ifu_prefetch_buf
   import ifu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 8 * INST_BYTES,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              inst_valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   input  logic              inst_ready_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_rvalid_i,
   input  logic [INST_W-1:0] mem_rdata_i
);

   localparam int unsigned IncBytes = inst_bytes(INST_W);
   localparam int unsigned CntW     = $clog2(DEPTH + 1);

   ifu_state_e              state_q, state_d;
   logic [ADDR_W-1:0]       fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]       issued_pc_q, issued_pc_d;
   logic                    push, pop;
   logic [CntW-1:0]         count;
   logic [ADDR_W+INST_W-1:0] head;

   assign inst_valid_o = (count != '0);
   assign pop          = inst_valid_o && inst_ready_i;
   assign {inst_addr_o, inst_o} = head;
   assign mem_addr_o   = fetch_pc_q;

   // Fetch FSM next state, request issue and response push decision.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      issued_pc_d = issued_pc_q;
      mem_req_o   = 1'b0;
      push        = 1'b0;
      if (redirect_i) fetch_pc_d = redirect_pc_i;
      unique case (state_q)
         StIdle: begin
            // rst gating keeps the request low while reset is held.
            if (rst && !redirect_i && (count < CntW'(DEPTH))) begin
               mem_req_o   = 1'b1;
               issued_pc_d = fetch_pc_q;
               fetch_pc_d  = fetch_pc_q + ADDR_W'(IncBytes);
               state_d     = StReq;
            end
         end
         StReq: begin
            if (mem_rvalid_i) begin
               push    = !redirect_i;
               state_d = StIdle;
            end else if (redirect_i) begin
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (mem_rvalid_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM and PC registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         fetch_pc_q  <= RESET_PC;
         issued_pc_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         issued_pc_q <= issued_pc_d;
      end
   end

   ifu_fifo #(
      .WIDTH (ADDR_W + INST_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push),
      .wdata_i ({issued_pc_q, mem_rdata_i}),
      .pop_i   (pop),
      .flush_i (redirect_i),
      .rdata_o (head),
      .count_o (count)
   );

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Self-checking bench for ifu_prefetch_buf: a queue-based reference model,
// a latency-programmable memory responder, table vectors and corner cases.
module tb_ifu_prefetch_buf;

   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_ready_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   always #5 clk = ~clk;

   ifu_prefetch_buf #(
      .ADDR_W   (32),
      .INST_W   (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_addr_o   (inst_addr_o),
      .inst_ready_i  (inst_ready_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i)
   );

   int n_pass = 0;
   int n_tot  = 0;

   // Reference model: queue of buffered {pc, data} plus fetch bookkeeping.
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pc, m_issued;
   bit          m_out, m_drop;

   // Memory responder state.
   bit          r_pend;
   int          r_wait;
   logic [31:0] r_addr;
   int          lat;

   // Samples from the most recent cycle.
   logic        s_valid, s_req;
   logic [31:0] s_iaddr, s_inst, s_maddr;
   int          n_req;
   logic [31:0] last_req, first_req;

   typedef struct {
      bit          rdy;
      bit          e_valid;
      logic [31:0] e_iaddr;
      bit          e_req;
      logic [31:0] e_maddr;
   } vec_t;
   vec_t tbl[7];

   function automatic logic [31:0] fnmem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", nm, act, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc     = RST_PC;
      m_issued = RST_PC;
      m_out    = 1'b0;
      m_drop   = 1'b0;
      r_pend   = 1'b0;
      r_wait   = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      inst_ready_i  = 1'b0;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = '0;
      #1;
      chk("reset_valid", 32'(inst_valid_o), 32'd0);
      chk("reset_req", 32'(mem_req_o), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // One clock cycle: drive inputs, check against the model, advance it.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit stray);
      bit   rv, resp, e_valid, e_req;
      ent_t h;
      @(negedge clk);
      resp          = r_pend && (r_wait == 0);
      rv            = resp || stray;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      inst_ready_i  = rdy;
      mem_rvalid_i  = rv;
      mem_rdata_i   = resp ? fnmem(r_addr) : $urandom;
      #1;
      s_valid = inst_valid_o;
      s_iaddr = inst_addr_o;
      s_inst  = inst_o;
      s_req   = mem_req_o;
      s_maddr = mem_addr_o;
      e_valid = (m_q.size() != 0);
      e_req   = !m_out && (m_q.size() < DEPTH) && !redir;
      chk("inst_valid", 32'(s_valid), 32'(e_valid));
      if (e_valid) begin
         h = m_q[0];
         chk("inst_addr", s_iaddr, h.a);
         chk("inst_data", s_inst, h.d);
      end
      chk("mem_req", 32'(s_req), 32'(e_req));
      if (e_req) chk("mem_addr", s_maddr, m_pc);
      if (s_req) begin
         if (n_req == 0) first_req = s_maddr;
         n_req++;
         last_req = s_maddr;
      end
      // Model update at the coming edge: pop, then response, then issue, then flush.
      if (e_valid && rdy) void'(m_q.pop_front());
      if (m_out && rv) begin
         if (!m_drop && !redir) m_q.push_back('{a: m_issued, d: fnmem(m_issued)});
         m_out  = 1'b0;
         m_drop = 1'b0;
      end else if (m_out && redir) begin
         m_drop = 1'b1;
      end
      if (e_req) begin
         m_out    = 1'b1;
         m_issued = m_pc;
         m_pc     = m_pc + 32'd4;
      end
      if (redir) begin
         m_q.delete();
         m_pc = rpc;
      end
      // Memory responder: answer lat cycles after the request cycle.
      if (resp) r_pend = 1'b0;
      else if (r_pend) r_wait--;
      if (s_req) begin
         r_pend = 1'b1;
         r_wait = lat - 1;
         r_addr = s_maddr;
      end
      @(posedge clk);
   endtask

   initial begin
      rst = 1'b0;
      lat = 1;
      n_req = 0;
      model_reset();

      // Streaming at latency 1 with ready high: one instruction per 2 cycles.
      tbl[0] = '{1'b1, 1'b0, 32'h0,           1'b1, 32'h8000_0000};
      tbl[1] = '{1'b1, 1'b0, 32'h0,           1'b0, 32'h0};
      tbl[2] = '{1'b1, 1'b1, 32'h8000_0000,   1'b1, 32'h8000_0004};
      tbl[3] = '{1'b1, 1'b0, 32'h0,           1'b0, 32'h0};
      tbl[4] = '{1'b1, 1'b1, 32'h8000_0004,   1'b1, 32'h8000_0008};
      tbl[5] = '{1'b1, 1'b0, 32'h0,           1'b0, 32'h0};
      tbl[6] = '{1'b1, 1'b1, 32'h8000_0008,   1'b1, 32'h8000_000c};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 32'h0, tbl[i].rdy, 1'b0);
         chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
         if (tbl[i].e_valid) chk($sformatf("tbl%0d_iaddr", i), s_iaddr, tbl[i].e_iaddr);
         chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
         if (tbl[i].e_req) chk($sformatf("tbl%0d_maddr", i), s_maddr, tbl[i].e_maddr);
      end

      // Fill to DEPTH with ready low at latency 3, then drain.
      do_reset();
      lat   = 3;
      n_req = 0;
      for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("full_nreq", 32'(n_req), 32'd4);
      chk("full_valid", 32'(s_valid), 32'd1);
      chk("full_head", s_inst, fnmem(RST_PC));
      n_req = 0;
      for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("resume_addr", first_req, 32'h8000_0010);

      // Redirect while a request is outstanding: response must be dropped.
      do_reset();
      lat = 1;
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      lat = 3;
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h8000_0100, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drop_empty", 32'(s_valid), 32'd0);
      n_req = 0;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drop_nreq", 32'(n_req), 32'd1);
      chk("drop_addr", last_req, 32'h8000_0100);

      // Redirect coinciding with the response.
      do_reset();
      lat = 1;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'h8000_0200, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("same_req", 32'(s_req), 32'd1);
      chk("same_addr", s_maddr, 32'h8000_0200);
      chk("same_valid", 32'(s_valid), 32'd0);

      // PC wrap from the top of the address space.
      do_reset();
      lat = 1;
      step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_first", s_maddr, 32'hFFFF_FFFC);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_req", 32'(s_req), 32'd1);
      chk("wrap_addr", s_maddr, 32'h0000_0000);

      // Reset mid-request with two buffered entries, then a stray response.
      do_reset();
      lat = 1;
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("pre_rst_valid", 32'(s_valid), 32'd1);
      do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("post_rst_req", 32'(s_req), 32'd1);
      chk("post_rst_addr", s_maddr, RST_PC);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("stray_ignored", 32'(s_valid), 32'd0);

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         lat = $urandom_range(1, 4);
         step($urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 3) != 0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
